fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch controller between the PC register and the IF/ID boundary. Takes the current PC, runs a req/ack handshake with a variable-latency instruction memory, and delivers {pc, instruction, valid} to the decode stage. Pulses the PC write-enable when a fetch completes or a redirect occurs. Handles decode stalls with a one-entry hold buffer and drops in-flight fetches on flush.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk_i  in  1  clock, rising edge.
- start_i  in  1  asynchronous active-low reset.
- pc_i  in  32  current PC from the PC register.
- pcWrite_o  out  1  PC write-enable; one-cycle pulses.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address; stable while imem_req_o=1.
- imem_ack_i  in  1  memory completion; imem_data_i valid this cycle.
- imem_data_i  in  32  fetched instruction.
- stall_i  in  1  decode cannot accept; IF/ID holds.
- flush_i  in  1  redirect; PC source mux already selects the target.
- ifid_pc_o  out  32  PC of delivered instruction.
- ifid_inst_o  out  32  delivered instruction.
- ifid_valid_o  out  1  IF/ID entry holds a valid instruction.

## Operation
- States: IDLE, ISSUE, REQ, HOLD.
- IDLE: entered on reset; next edge goes to ISSUE.
- ISSUE: imem_req_o=0. At the edge, latch pc_i into addr_q, then go to REQ.
- REQ: imem_req_o=1, imem_addr_o=addr_q.
  - Stays in REQ until imem_ack_i=1.
  - Ack with no flush and no pending drop: pcWrite_o=1 this cycle, and the instruction is accepted.
    - If the IF/ID slot is free (ifid_valid_o=0 or stall_i=0), load {addr_q, imem_data_i, 1} into IF/ID and go to ISSUE.
    - Otherwise, write the instruction into the hold buffer and go to HOLD.
- HOLD: when stall_i=0, move the hold buffer into IF/ID and go to ISSUE. pcWrite_o=0.
- IF/ID update, highest priority first:
  - flush_i=1: ifid_valid_o←0, ifid_inst_o←0.
  - stall_i=1 and ifid_valid_o=1: hold.
  - Otherwise: load new data if available, else ifid_valid_o←0 (bubble).
- Flush, in ISSUE, REQ or HOLD:
  - pcWrite_o=1 that cycle.
  - ISSUE or HOLD: go to ISSUE; hold buffer discarded.
  - REQ without ack: set drop_q and remain in REQ; the handshake is never abandoned.
  - REQ with ack the same cycle: discard the data, go to ISSUE.
- Ack with drop_q=1: discard the data, pcWrite_o=0, clear drop_q, go to ISSUE.
- flush_i in IDLE: ignored.
- Flush has priority over stall everywhere.

## Timing
- Reset values: all outputs 0, state IDLE, addr_q=0, drop_q=0.
- Reset mid-request: abandon immediately; imem_req_o=0 asynchronously.
- Minimum fetch period: 2 cycles (ISSUE, REQ with same-cycle ack).
  - ifid_valid_o rises the edge after the ack.
  - The PC updates on that same edge; the next ISSUE latches the new PC.
- imem_addr_o changes only on ISSUE→REQ edges.
- pcWrite_o is never high for two consecutive cycles except on back-to-back flushes.

## Configuration
- FETCH_PERF_EN defined adds two outputs:
  - fetch_cnt_o (out, 32): instructions loaded into IF/ID, discarded fetches excluded.
  - stall_cnt_o (out, 32): cycles in REQ without ack plus cycles in HOLD.
  - Both reset to 0 and wrap from 32'hFFFF_FFFF to 0.
- FETCH_PERF_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package fetch_pkg holds:
  - the state enum: IDLE=2'd0, ISSUE=2'd1, REQ=2'd2, HOLD=2'd3;
  - INST_NOP=32'h0000_0000;
  - XLEN=32.
- One sub-module: ifid_stage_reg, the IF/ID register with stall/flush priority and load-new/bubble select. The FSM, hold buffer and drop_q stay in fetch_unit.

## Test plan
- Reset, then pc_i=32'h0, ack 1 cycle after req with data 32'h2001_0005, stall_i=0 → imem_addr_o=0; pcWrite_o pulse on the ack cycle; next cycle ifid_pc_o=0, ifid_inst_o=32'h2001_0005, ifid_valid_o=1.
- Streaming, memory acks each REQ cycle, PC steps 0,4,8 → ifid_pc_o sequence 0,4,8; one instruction per 2 cycles; ifid_valid_o=0 in bubble cycles.
- stall_i held high 4 cycles while IF/ID valid; ack for pc 32'h8 arrives → state HOLD; IF/ID unchanged; when stall drops, ifid_pc_o=32'h8 next cycle.
- flush_i during REQ (ack 3 cycles later), redirect target 32'h40 → pcWrite_o pulse on the flush cycle; returned data discarded with no second pulse; next request address 32'h40.
- flush_i and imem_ack_i in the same cycle → data discarded, one pcWrite_o pulse, ifid_valid_o=0 next cycle.
- start_i low while imem_req_o=1 → imem_req_o and all outputs 0 immediately; after release, first request is pc_i. With FETCH_PERF_EN: after 3 delivered instructions and 5 wait cycles, fetch_cnt_o=3 and stall_cnt_o=5.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: the FSM state
// encoding, the datapath width and the bubble instruction value.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        REQ   = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_ifid_stage_reg.sv
// IF/ID pipeline register. A flush wins over everything and inserts a NOP,
// a stall keeps a valid entry in place, and otherwise the register either
// takes the offered instruction or turns into a bubble.
import fetch_pkg::*;

module ifid_stage_reg (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            stall,
    input  logic            load,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_inst,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] inst,
    output logic            valid
);

    // Register update: flush, then stall-hold, then load-or-bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            inst  <= INST_NOP;
            valid <= 1'b0;
        end else if (flush) begin
            inst  <= INST_NOP;
            valid <= 1'b0;
        end else if (!(stall && valid)) begin
            if (load) begin
                pc    <= load_pc;
                inst  <= load_inst;
                valid <= 1'b1;
            end else begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch controller: latches the PC, runs a req/ack handshake
// with a variable-latency instruction memory and delivers the result into
// the IF/ID register, parking it in a one-entry hold buffer while decode
// stalls. A flush during an outstanding request lets the handshake finish
// but throws the returned data away.
// Optional build macro FETCH_PERF_EN adds fetch and stall counters.
import fetch_pkg::*;

module fetch_unit (
    input  logic            clk_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            pcWrite_o,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_data_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic [XLEN-1:0] ifid_inst_o,
    output logic            ifid_valid_o
`ifdef FETCH_PERF_EN
    ,
    output logic [XLEN-1:0] fetch_cnt_o,
    output logic [XLEN-1:0] stall_cnt_o
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] hold_inst_q;
    logic            drop_q, drop_d;
    logic            addr_load;
    logic            hold_load;
    logic            ifid_load;
    logic            ifid_flush;
    logic            slot_free;
    logic [XLEN-1:0] ifid_load_inst;

    assign imem_req_o     = (state_q == REQ);
    assign imem_addr_o    = addr_q;
    assign slot_free      = !ifid_valid_o || !stall_i;
    assign ifid_flush     = flush_i && (state_q != IDLE);
    // The hold buffer only ever feeds IF/ID from HOLD; addr_q is still the
    // PC of that instruction because it only moves on the next ISSUE.
    assign ifid_load_inst = (state_q == HOLD) ? hold_inst_q : imem_data_i;

    // State, fetch address, drop flag and hold buffer registers.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            drop_q      <= 1'b0;
            hold_inst_q <= INST_NOP;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            if (addr_load) begin
                addr_q <= pc_i;
            end
            if (hold_load) begin
                hold_inst_q <= imem_data_i;
            end
        end
    end

    // Next-state logic plus the PC write pulse and IF/ID / hold-buffer loads.
    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        pcWrite_o = 1'b0;
        addr_load = 1'b0;
        hold_load = 1'b0;
        ifid_load = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = ISSUE;
            end
            ISSUE: begin
                if (flush_i) begin
                    pcWrite_o = 1'b1;
                end else begin
                    addr_load = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (imem_ack_i) begin
                    state_d = ISSUE;
                    drop_d  = 1'b0;
                    if (flush_i) begin
                        pcWrite_o = 1'b1;
                    end else if (!drop_q) begin
                        pcWrite_o = 1'b1;
                        if (slot_free) begin
                            ifid_load = 1'b1;
                        end else begin
                            hold_load = 1'b1;
                            state_d   = HOLD;
                        end
                    end
                end else if (flush_i) begin
                    pcWrite_o = 1'b1;
                    drop_d    = 1'b1;
                end
            end
            HOLD: begin
                if (flush_i) begin
                    pcWrite_o = 1'b1;
                    state_d   = ISSUE;
                end else if (!stall_i) begin
                    ifid_load = 1'b1;
                    state_d   = ISSUE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    ifid_stage_reg u_ifid (
        .clk       (clk_i),
        .rst_n     (start_i),
        .flush     (ifid_flush),
        .stall     (stall_i),
        .load      (ifid_load),
        .load_pc   (addr_q),
        .load_inst (ifid_load_inst),
        .pc        (ifid_pc_o),
        .inst      (ifid_inst_o),
        .valid     (ifid_valid_o)
    );

`ifdef FETCH_PERF_EN
    // Delivered-instruction and memory/decode wait-cycle counters.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            fetch_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (ifid_load) begin
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            end
            if ((state_q == REQ && !imem_ack_i) || state_q == HOLD) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
